sram_access_ctrl: RTL
=====================

Name: sram_access_ctrl

Overview:
- Owns the external 16-bit SRAM bus and sequences every access to it.
- Arbitrates between two requesters: the recorder write stream (from I2S) and the player read stream (to DSP).
- Maintains the record pointer (write) and play pointer (read). The recorded length bounds playback.
- Replaces ad-hoc per-state SRAM pin driving with a single 2-phase access FSM and round-robin grant.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- MAX_ADDR, 20'hFFFFF, last writable word address.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- wr_valid  in  1  recorder has a sample
- wr_data  in  DATA_W  sample to store
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_clear  in  1  restart recording at address 0
- rd_req  in  1  player requests next sample
- rd_ready  out  1  read accepted when rd_req & rd_ready
- rd_restart  in  1  restart playback at address 0
- rd_data  out  DATA_W  fetched sample
- rd_valid  out  1  one-cycle strobe qualifying rd_data
- rec_len  out  ADDR_W+1  number of words recorded (wr_ptr)
- play_addr  out  ADDR_W  current play pointer
- full  out  1  recording reached MAX_ADDR+1 words
- play_end  out  1  play pointer == rec_len (nothing left to play)
- SRAM_ADDR  out  ADDR_W;  SRAM_DQ  inout  DATA_W;  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each

Behaviour:
- Reset (sync, i_rst=1 at posedge): FSM=IDLE, wr_ptr=0, rd_ptr=0, full=0, rd_valid=0, rd_data=0, SRAM_ADDR=0, all SRAM_*_N=1, SRAM_DQ released (Z), last_grant=READ. Reset mid-access aborts it next edge; no partial write is completed.
- FSM states: IDLE, WR_SETUP, WR_PULSE, RD_ADDR, RD_SAMPLE.
- IDLE: wr_ready = ~full & ~wr_clear & ~(rd_req & rd_ready_win). rd_ready = ~play_end & ~rd_restart & (grant==READ). Both are combinational from state/arbiter; neither is ever high outside IDLE.
- Arbitration in IDLE: if only one eligible requester, grant it. If both, grant the one opposite last_grant; update last_grant on each grant. The first contention after reset therefore goes to WRITE.
- Write: accept at T → WR_SETUP at T+1: SRAM_ADDR=wr_ptr, DQ driven with latched wr_data, CE_N=0, WE_N=1, UB_N=LB_N=0. WR_PULSE at T+2: WE_N=0. Back to IDLE at T+3 with WE_N=1 and wr_ptr+1. Throughput is one write per 3 cycles.
- full: set in the cycle wr_ptr increments to MAX_ADDR+1. Held until wr_clear or reset.
- Read: accept at T → RD_ADDR at T+1: SRAM_ADDR=rd_ptr, CE_N=0, OE_N=0, WE_N=1, DQ released. RD_SAMPLE at T+2 holds the bus; rd_data captures SRAM_DQ at the end of RD_SAMPLE. rd_valid=1 for exactly cycle T+3, and rd_ptr+1 in that same cycle.
- play_end = (rd_ptr == wr_ptr). A rd_req while play_end is ignored (no rd_valid).
- wr_clear / rd_restart: take effect only in IDLE; otherwise honoured on the return to IDLE. wr_clear zeros wr_ptr, full, and rd_ptr. rd_restart zeros rd_ptr only. If both occur in one cycle, wr_clear semantics apply.
- DQ: driven only in WR_SETUP/WR_PULSE; Z in all other states, including reset.
- Width rule: wr_ptr is ADDR_W+1 bits so a full memory is distinguishable from empty. rd_ptr never exceeds wr_ptr. There is no wrap-around; a full recorder stays full.

Decomposition:
- Package sram_ctrl_pkg holds: the state enum (IDLE, WR_SETUP, WR_PULSE, RD_ADDR, RD_SAMPLE), the grant enum (WRITE, READ), and localparams ADDR_W/DATA_W defaults.
- One sub-module, sram_rr_arb2: a 2-requester round-robin arbiter holding last_grant, with inputs req_wr, req_rd, advance and outputs gnt_wr, gnt_rd.
- FSM, pointers and pin registers stay in the top.

Test Plan:
- Reset then 4 writes 0x1111..0x4444 (wr_valid held) → WE_N low at cycles 2,5,8,11 after first accept; SRAM_ADDR 0..3; rec_len=4; wr_ready high only in IDLE cycles.
- After that, 5 read requests with the SRAM model returning stored data → rd_valid 4 times with 0x1111..0x4444, each 3 cycles after accept; 5th request ignored; play_end=1.
- wr_valid and rd_req both held continuously from reset → grants alternate W,R,W,R; first grant is WRITE; no overlapping CE_N=0 windows.
- Preload wr_ptr to MAX_ADDR, then one write → full=1; wr_ready=0 thereafter; wr_clear → full=0, rec_len=0, play_addr=0.
- Assert i_rst during WR_PULSE → next edge WE_N=1, CE_N=1, DQ=Z, rec_len=0, FSM IDLE.
- rd_restart pulsed during RD_ADDR at play_addr=2 → rd_valid still delivers address 2 data; play_addr=0 on return to IDLE.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default widths for the SRAM access controller and its arbiter.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_RD_ADDR,
        ST_RD_SAMPLE
    } state_t;

    typedef enum logic {
        GNT_WRITE,
        GNT_READ
    } grant_t;

endpackage

// File: rtl/sram_access_ctrl_arb.sv
// Two-requester round-robin arbiter: a contended grant goes to the side that was not served last.
module sram_rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_wr,
    input  logic req_rd,
    input  logic advance,
    output logic gnt_wr,
    output logic gnt_rd
);

    grant_t last_grant_q;

    always_comb begin
        gnt_wr = req_wr & (~req_rd | (last_grant_q == GNT_READ));
        gnt_rd = req_rd & (~req_wr | (last_grant_q == GNT_WRITE));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= GNT_READ;
        end else if (advance && gnt_wr) begin
            last_grant_q <= GNT_WRITE;
        end else if (advance && gnt_rd) begin
            last_grant_q <= GNT_READ;
        end
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// Owns the external SRAM bus: arbitrates recorder writes against player reads and runs
// each access as a registered two-phase sequence, tracking record and play pointers.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = SRAM_ADDR_W,
    parameter int                DATA_W   = SRAM_DATA_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              wr_clear,
    input  logic              rd_req,
    output logic              rd_ready,
    input  logic              rd_restart,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   rec_len,
    output logic [ADDR_W-1:0] play_addr,
    output logic              full,
    output logic              play_end,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] FULL_CNT = {1'b0, MAX_ADDR} + PTR_ONE;

    state_t              state_q;
    logic [ADDR_W:0]     wr_ptr_q, rd_ptr_q;
    logic                full_q, rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q, dq_out_q;
    logic                dq_oe_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                ce_n_q, oe_n_q, we_n_q, bls_n_q;
    logic                clr_pend_q, rst_pend_q;

    logic                in_idle, play_end_w, req_wr, req_rd, gnt_wr, gnt_rd;
    logic                clr_now, rst_now;
    logic [ADDR_W:0]     wr_ptr_d, rd_ptr_d;

    assign in_idle    = (state_q == ST_IDLE);
    assign play_end_w = (rd_ptr_q == wr_ptr_q);
    assign req_wr     = in_idle & wr_valid & ~full_q & ~wr_clear;
    // A clear also empties the playback range, so no read may start alongside it.
    assign req_rd     = in_idle & rd_req & ~play_end_w & ~rd_restart & ~wr_clear;
    assign clr_now    = wr_clear | clr_pend_q;
    assign rst_now    = rd_restart | rst_pend_q;
    assign wr_ptr_d   = wr_ptr_q + PTR_ONE;
    assign rd_ptr_d   = rd_ptr_q + PTR_ONE;

    sram_rr_arb2 u_arb (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .req_wr  (req_wr),
        .req_rd  (req_rd),
        .advance (in_idle),
        .gnt_wr  (gnt_wr),
        .gnt_rd  (gnt_rd)
    );

    assign wr_ready = in_idle & ~full_q & ~wr_clear & ~gnt_rd;
    assign rd_ready = gnt_rd;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
            addr_q     <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            bls_n_q    <= 1'b1;
            clr_pend_q <= 1'b0;
            rst_pend_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            // Clear/restart seen mid-access are held until the access returns to idle.
            clr_pend_q <= ~in_idle & clr_now;
            rst_pend_q <= ~in_idle & rst_now;
            case (state_q)
                ST_IDLE: begin
                    if (clr_now) begin
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        full_q   <= 1'b0;
                    end else if (rst_now) begin
                        rd_ptr_q <= '0;
                    end
                    if (gnt_wr) begin
                        state_q  <= ST_WR_SETUP;
                        addr_q   <= wr_ptr_q[ADDR_W-1:0];
                        dq_out_q <= wr_data;
                        dq_oe_q  <= 1'b1;
                        ce_n_q   <= 1'b0;
                        oe_n_q   <= 1'b1;
                        we_n_q   <= 1'b1;
                        bls_n_q  <= 1'b0;
                    end else if (gnt_rd) begin
                        state_q  <= ST_RD_ADDR;
                        addr_q   <= rd_ptr_q[ADDR_W-1:0];
                        dq_oe_q  <= 1'b0;
                        ce_n_q   <= 1'b0;
                        oe_n_q   <= 1'b0;
                        we_n_q   <= 1'b1;
                        bls_n_q  <= 1'b0;
                    end
                end
                ST_WR_SETUP: begin
                    state_q <= ST_WR_PULSE;
                    we_n_q  <= 1'b0;
                end
                ST_WR_PULSE: begin
                    state_q    <= ST_IDLE;
                    we_n_q     <= 1'b1;
                    ce_n_q     <= 1'b1;
                    bls_n_q    <= 1'b1;
                    dq_oe_q    <= 1'b0;
                    clr_pend_q <= 1'b0;
                    rst_pend_q <= 1'b0;
                    if (clr_now) begin
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        full_q   <= 1'b0;
                    end else begin
                        wr_ptr_q <= wr_ptr_d;
                        full_q   <= (wr_ptr_d == FULL_CNT);
                        if (rst_now) begin
                            rd_ptr_q <= '0;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    state_q <= ST_RD_SAMPLE;
                end
                ST_RD_SAMPLE: begin
                    state_q    <= ST_IDLE;
                    ce_n_q     <= 1'b1;
                    oe_n_q     <= 1'b1;
                    bls_n_q    <= 1'b1;
                    rd_data_q  <= SRAM_DQ;
                    rd_valid_q <= 1'b1;
                    clr_pend_q <= 1'b0;
                    rst_pend_q <= 1'b0;
                    if (clr_now) begin
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        full_q   <= 1'b0;
                    end else if (rst_now) begin
                        rd_ptr_q <= '0;
                    end else begin
                        rd_ptr_q <= rd_ptr_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};
    assign SRAM_ADDR = addr_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = bls_n_q;
    assign SRAM_LB_N = bls_n_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rec_len   = wr_ptr_q;
    assign play_addr = rd_ptr_q[ADDR_W-1:0];
    assign full      = full_q;
    assign play_end  = play_end_w;

endmodule
